// File: rtl/fifo_wr_pkg.sv
// Shared types and default widths for the FIFO write-side front end.
package fifo_wr_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        TIMEOUT = 2'd2
    } wr_state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Producer stream plus FIFO write port, bundled for the write-side front end.
interface fifo_wr_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              wenable;
    logic [DATA_W-1:0] wdata;
    logic              full;

    modport master (
        output s_valid,
        output s_data,
        output full,
        input  s_ready,
        input  wenable,
        input  wdata
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  full,
        output s_ready,
        output wenable,
        output wdata
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: entry0 is always the head, s_ready is registered.
module fifo_skid_buf
    import fifo_wr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output occ_t              occ,
    output logic [DATA_W-1:0] head,
    output logic              ready
);

    logic [DATA_W-1:0] entry0;
    logic [DATA_W-1:0] entry1;
    occ_t              occ_next;

    // Occupancy after this cycle's push and pop.
    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    // Entry storage, occupancy and ready; entry0 keeps its value when the buffer drains.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            occ    <= 2'd0;
            ready  <= 1'b0;
        end else begin
            occ   <= occ_next;
            ready <= (occ_next < 2'd2);
            if (pop) begin
                if (occ == 2'd2) begin
                    entry0 <= entry1;
                end else if (push) begin
                    entry0 <= push_data;
                end
            end else if (push) begin
                if (occ == 2'd0) begin
                    entry0 <= push_data;
                end else begin
                    entry1 <= push_data;
                end
            end
        end
    end

    assign head = entry0;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain front end: skid buffer, full-gated FIFO writes, stats and stall timeout.
module fifo_wr_ctrl
    import fifo_wr_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int STALL_TIMEOUT = 256
) (
    input  logic             wclk,
    input  logic             wrst_n,
    fifo_wr_ctrl_if.slave    bus,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] stall_count,
    output logic             timeout
);

    localparam int RL_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [RL_W-1:0] RL_LIMIT = RL_W'(STALL_TIMEOUT);

    occ_t            occ;
    logic            accept;
    logic            stall;
    wr_state_e       state_q;
    wr_state_e       state_d;
    logic [RL_W-1:0] run_len_q;
    logic [RL_W-1:0] run_len_d;
    logic [RL_W-1:0] run_len_inc;

    assign accept      = bus.s_valid & bus.s_ready;
    assign bus.wenable = (occ != 2'd0) & ~bus.full;
    assign stall       = (occ != 2'd0) & bus.full;
    assign run_len_inc = run_len_q + RL_W'(1);
    assign timeout     = (state_q == TIMEOUT);

    fifo_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .push      (accept),
        .pop       (bus.wenable),
        .push_data (bus.s_data),
        .occ       (occ),
        .head      (bus.wdata),
        .ready     (bus.s_ready)
    );

    // Write and stall statistics; a clear beats any increment in the same cycle.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_count    <= '0;
            stall_count <= '0;
        end else if (clr_stats) begin
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (bus.wenable) begin
                wr_count <= wr_count + CNT_W'(1);
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    // Stall FSM state and run-length registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q   <= RUN;
            run_len_q <= '0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
        end
    end

    // Next state: entering TIMEOUT on the edge that completes the limiting stall cycle.
    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        case (state_q)
            RUN: begin
                if (stall) begin
                    state_d   = STALL;
                    run_len_d = RL_W'(1);
                end
            end
            STALL: begin
                if (!stall) begin
                    state_d   = RUN;
                    run_len_d = '0;
                end else if (run_len_inc == RL_LIMIT) begin
                    state_d   = TIMEOUT;
                    run_len_d = '0;
                end else begin
                    run_len_d = run_len_inc;
                end
            end
            TIMEOUT: begin
                run_len_d = '0;
                if (clr_stats) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d   = RUN;
                run_len_d = '0;
            end
        endcase
    end

endmodule
